// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// Covers FSM states, opcode/funct values, ALU codes and datapath mux selects.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_MEM = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_BRANCH = 4'd8,
    S_EXEC_I = 4'd9,
    S_WB_I   = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_decode.sv
// ALU-control decode: maps ALUOp and funct to the ALU operation code.
// Flags any funct outside the supported R-type set when ALUOp selects funct.
module mips_multicycle_control_alu_decode
  import mips_multicycle_control_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  aluop_e               i_aluop,
  input  logic [5:0]           i_funct,
  output logic [ALUCTRL_W-1:0] o_alu_control,
  output logic                 o_funct_illegal
);

  logic [3:0] w_code;

  always_comb begin
    w_code          = ALU_ADD;
    o_funct_illegal = 1'b0;
    case (i_aluop)
      ALUOP_ADD: w_code = ALU_ADD;
      ALUOP_SUB: w_code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  w_code = ALU_ADD;
          FN_SUB:  w_code = ALU_SUB;
          FN_AND:  w_code = ALU_AND;
          FN_OR:   w_code = ALU_OR;
          FN_NOR:  w_code = ALU_NOR;
          FN_SLT:  w_code = ALU_SLT;
          default: o_funct_illegal = 1'b1;
        endcase
      end
      default: w_code = ALU_ADD;
    endcase
  end

  assign o_alu_control = ALUCTRL_W'(w_code);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: state machine, datapath enables, sticky illegal
// flag and retired-instruction counter. Outputs are decoded from the current state.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int ALUCTRL_W       = 4,
  parameter int CNT_W           = 32,
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_source,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal,
  output logic                 instr_retired,
  output logic [CNT_W-1:0]     retired_count,
  output logic [3:0]           state_dbg
);

  state_e               r_state;
  logic                 r_illegal;
  logic [CNT_W-1:0]     r_count;

  logic                 w_ready;
  logic                 w_op_legal;
  logic                 w_funct_illegal;
  logic                 w_unused_zero;
  aluop_e               w_aluop;
  logic [ALUCTRL_W-1:0] w_alu_control;

  logic       w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write;
  logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic       w_retire;
  logic [1:0] w_alu_src_b, w_pc_source;

  // The branch decision (pc_write_cond & zero) is formed in the datapath.
  assign w_unused_zero = zero;
  assign w_ready       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign w_op_legal    = opcode_legal(opcode);

  mips_multicycle_control_alu_decode #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_decode (
    .i_aluop        (w_aluop),
    .i_funct        (funct),
    .o_alu_control  (w_alu_control),
    .o_funct_illegal(w_funct_illegal)
  );

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_B;
    w_pc_source     = PCSRC_ALU;
    w_aluop         = ALUOP_ADD;
    w_retire        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = w_ready;
        w_pc_write  = w_ready;
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMMSH;
        w_retire    = !w_op_legal && !TRAP_ON_ILLEGAL;
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        w_retire    = w_ready;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_aluop     = ALUOP_FUNCT;
        w_retire    = w_funct_illegal && !TRAP_ON_ILLEGAL;
      end
      S_WB_R: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_aluop         = ALUOP_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCSRC_ALUOUT;
        w_retire        = 1'b1;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      S_WB_I: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = PCSRC_JUMP;
        w_retire    = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces every output low at once, even mid-access.
  assign pc_write      = w_pc_write & ~reset;
  assign pc_write_cond = w_pc_write_cond & ~reset;
  assign iord          = w_iord & ~reset;
  assign mem_read      = w_mem_read & ~reset;
  assign mem_write     = w_mem_write & ~reset;
  assign ir_write      = w_ir_write & ~reset;
  assign mem_to_reg    = w_mem_to_reg & ~reset;
  assign reg_dst       = w_reg_dst & ~reset;
  assign reg_write     = w_reg_write & ~reset;
  assign alu_src_a     = w_alu_src_a & ~reset;
  assign alu_src_b     = reset ? 2'b00 : w_alu_src_b;
  assign pc_source     = reset ? 2'b00 : w_pc_source;
  assign alu_control   = reset ? '0 : w_alu_control;
  assign instr_retired = w_retire & ~reset;
  assign illegal       = r_illegal;
  assign retired_count = r_count;
  assign state_dbg     = r_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_retire) r_count <= r_count + CNT_W'(1);
      case (r_state)
        S_FETCH:  if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:     r_state <= S_EXEC_R;
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_EXEC_I;
            OP_J:         r_state <= S_JUMP;
            default: begin
              r_illegal <= 1'b1;
              r_state   <= TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
            end
          endcase
        end
        S_MEMADR: r_state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: if (w_ready) r_state <= S_WB_MEM;
        S_MEM_WR: if (w_ready) r_state <= S_FETCH;
        S_EXEC_R: begin
          if (w_funct_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
          end else begin
            r_state <= S_WB_R;
          end
        end
        S_EXEC_I: r_state <= S_WB_I;
        S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit.
- Combines a main control FSM (fetch / decode / execute / memory / writeback) with ALU-control decode.
- Drives all datapath enables per cycle and supports a memory ready handshake.
- Flags illegal opcodes and counts retired instructions; sits between the instruction register and the multi-cycle datapath.

Parameters:
ALUCTRL_W, 4, width of alu_control output
CNT_W, 32, width of retired-instruction counter
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored (treated as 1)
TRAP_ON_ILLEGAL, 1, 1: illegal opcode enters HALT; 0: illegal opcode retires as NOP

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (beq)
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
iord  out  1  0: address=PC, 1: address=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load IR
mem_to_reg  out  1  writeback source = MDR
reg_dst  out  1  destination = rd (1) or rt (0)
reg_write  out  1  register file write
alu_src_a  out  1  0: PC, 1: A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
alu_control  out  ALUCTRL_W  ALU operation code
illegal  out  1  sticky; set on unknown opcode/funct
instr_retired  out  1  one-cycle pulse when an instruction completes
retired_count  out  CNT_W  count of retired instructions, wraps
state_dbg  out  4  current FSM state encoding

Behaviour:
- Reset (async): state=FETCH; illegal=0; retired_count=0; all control outputs 0, except FETCH Moore outputs after release.
- Outputs are Moore, decoded from state, except pc_write_cond·zero, which the datapath gates.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD, pc_source=00.
  - ir_write=1 and pc_write=1 only in the cycle mem_ready=1; otherwise stay in FETCH.
  - With MEM_HANDSHAKE=0, FETCH lasts exactly 1 cycle.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23/0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x08 -> EXEC_I
  - 0x02 -> JUMP
  - else -> ILLEGAL handling
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - 0x20 ADD=0010, 0x22 SUB=0110, 0x24 AND=0000, 0x25 OR=0001, 0x27 NOR=1100, 0x2A SLT=0111.
  - Unknown funct: illegal=1, treated per TRAP_ON_ILLEGAL.
  - Next -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; retire; -> FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, iord=1; wait for mem_ready, then -> WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; retire; -> FETCH.
- MEM_WR: mem_write=1, iord=1; wait for mem_ready; retire on exit; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01; retire; -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ADD; -> WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0; retire; -> FETCH.
- JUMP: pc_write=1, pc_source=10; retire; -> FETCH.
- Illegal opcode:
  - illegal set in the DECODE cycle.
  - TRAP_ON_ILLEGAL=1: -> HALT. HALT asserts no enables and is left only by reset.
  - TRAP_ON_ILLEGAL=0: retire as NOP -> FETCH.
- Retirement:
  - instr_retired pulses exactly one cycle per instruction.
  - retired_count increments in the same edge and wraps from 2^CNT_W-1 to 0.
- mem_read and mem_write are never both 1; reg_write and mem_write are never both 1.
- Reset mid-access (e.g. during MEM_WR wait): outputs drop immediately and asynchronously; no retire pulse.
- Latencies with zero wait states: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3.

Decomposition:
- Shared package/header: state encodings, opcode/funct constants, ALU-control codes, alu_src_b and pc_source encodings.
- Natural sub-module: alu_control_decode (combinational funct/ALUOp -> alu_control + funct_illegal).
- The FSM, counter and illegal flag stay in the top.

Test Plan:
- Reset asserted mid-MEM_WR wait -> mem_write=0 immediately, state_dbg=FETCH, retired_count=0, no retire pulse.
- R-type add (opcode 0x00, funct 0x20), mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R; alu_control=0010 in EXEC_R; reg_write=1 and reg_dst=1 in cycle 4; retired_count 0->1.
- lw (0x23) with mem_ready held low 3 cycles in MEM_RD -> mem_read held 4 cycles; WB_MEM with mem_to_reg=1; total 8 cycles; one retire pulse.
- Sequence sw, beq, j, addi -> pc_write_cond only in BRANCH, pc_source=10 only in JUMP; retired_count=4; mem_write never coincident with reg_write.
- Opcode 0x3F, TRAP_ON_ILLEGAL=1 -> illegal=1 after DECODE, HALT held 20 cycles with all enables 0; with TRAP_ON_ILLEGAL=0 -> retire pulse, back to FETCH, illegal stays 1.
- CNT_W=4, 17 addi instructions -> retired_count wraps 15->0, final value 1; MEM_HANDSHAKE=0 with mem_ready=0 -> FETCH still 1 cycle.
